// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU.
// Operand stage, then result register; one op per cycle.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int RR_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic [15:0]      gnt_cnt0,
   output logic [15:0]      gnt_cnt1
);

   localparam logic RR = (RR_EN != 0);

   logic             lgp;
   logic             pick1;
   logic             acc0;
   logic             acc1;
   logic             acc;
   logic             s1_valid;
   logic             s1_src;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_op;

   // pick1 selects port 1 whenever it would win arbitration
   always_comb begin
      pick1 = 1'b0;
      if (req1_valid && !req0_valid) begin
         pick1 = 1'b1;
      end else if (req1_valid && req0_valid) begin
         pick1 = RR && !lgp;
      end
   end

   assign req0_ready = !stall && req0_valid && !pick1;
   assign req1_ready = !stall && req1_valid && pick1;
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;
   assign acc        = acc0 || acc1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lgp <= 1'b1;
      end else if (acc) begin
         lgp <= acc1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_src   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else begin
         s1_valid <= acc;
         if (acc) begin
            s1_src <= acc1;
            s1_a   <= acc1 ? req1_a : req0_a;
            s1_b   <= acc1 ? req1_b : req0_b;
            s1_op  <= acc1 ? req1_op : req0_op;
         end
      end
   end

   assign alu_a    = s1_valid ? s1_a : '0;
   assign alu_b    = s1_valid ? s1_b : '0;
   assign alu_ctrl = s1_valid ? s1_op : 4'd0;

   // Result bus holds its last value between responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         rsp0_valid <= s1_valid && !s1_src;
         rsp1_valid <= s1_valid && s1_src;
         if (s1_valid) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt0 <= 16'd0;
         gnt_cnt1 <= 16'd0;
      end else begin
         if (acc0 && gnt_cnt0 != 16'hFFFF) begin
            gnt_cnt0 <= gnt_cnt0 + 16'd1;
         end
         if (acc1 && gnt_cnt1 != 16'hFFFF) begin
            gnt_cnt1 <= gnt_cnt1 + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU
// attached to the alu_* port.
module tb_alu_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall;
   logic         v0, v1;
   logic         rdy0, rdy1;
   logic [W-1:0] a0, b0, a1, b1;
   logic [3:0]   op0, op1;
   logic         rv0, rv1;
   logic [W-1:0] res;
   logic         zero;
   logic [W-1:0] alu_a, alu_b, alu_res;
   logic [3:0]   alu_ctrl;
   logic         alu_z;
   logic [15:0]  cnt0, cnt1;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W), .RR_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .req0_valid(v0), .req0_ready(rdy0),
      .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(rdy1),
      .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .rsp0_valid(rv0), .rsp1_valid(rv1),
      .rsp_result(res), .rsp_zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_res), .alu_zero(alu_z),
      .gnt_cnt0(cnt0), .gnt_cnt1(cnt1)
   );

   always_comb begin
      alu_res = '0;
      unique case (alu_ctrl)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0110: alu_res = alu_a - alu_b;
         default: alu_res = '0;
      endcase
   end
   assign alu_z = (alu_res == '0);

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int j;
   logic [W-1:0] e;

   initial begin
      rst_n = 1'b0; stall = 1'b0;
      v0 = 0; v1 = 0;
      a0 = '0; b0 = '0; op0 = '0;
      a1 = '0; b1 = '0; op1 = '0;
      repeat (3) tick();
      check("rst_rv0", 64'(rv0), 0);
      check("rst_rv1", 64'(rv1), 0);
      check("rst_res", 64'(res), 0);
      check("rst_ctrl", 64'(alu_ctrl), 0);
      check("rst_cnt0", 64'(cnt0), 0);
      check("rst_cnt1", 64'(cnt1), 0);
      rst_n = 1'b1;
      tick();

      // contention: port 0 first, then alternate
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            v0 = 1; v1 = 1;
            a0 = 32'(i + 1); b0 = 32'd100; op0 = 4'b0010;
            a1 = 32'd50; b1 = 32'(i); op1 = 4'b0110;
            #1;
            check("rr_rdy0", 64'(rdy0), 64'(i % 2 == 0));
            check("rr_rdy1", 64'(rdy1), 64'(i % 2 == 1));
         end else begin
            v0 = 0; v1 = 0;
         end
         tick();
         if (i >= 1 && i <= 4) begin
            j = i - 1;
            e = (j % 2 == 0) ? 32'(j + 101) : 32'(50 - j);
            check("rr_rv0", 64'(rv0), 64'(j % 2 == 0));
            check("rr_rv1", 64'(rv1), 64'(j % 2 == 1));
            check("rr_res", 64'(res), 64'(e));
         end
      end
      check("rr_cnt0", 64'(cnt0), 2);
      check("rr_cnt1", 64'(cnt1), 2);

      // single op 5+3
      v0 = 1; a0 = 32'd5; b0 = 32'd3; op0 = 4'b0010;
      #1;
      check("one_rdy0", 64'(rdy0), 1);
      check("one_rdy1", 64'(rdy1), 0);
      tick();
      v0 = 0;
      check("one_alu_a", 64'(alu_a), 5);
      check("one_alu_b", 64'(alu_b), 3);
      check("one_ctrl", 64'(alu_ctrl), 2);
      check("one_early", 64'(rv0), 0);
      tick();
      check("one_rv0", 64'(rv0), 1);
      check("one_rv1", 64'(rv1), 0);
      check("one_res", 64'(res), 8);
      check("one_zero", 64'(zero), 0);
      tick();
      check("one_pulse", 64'(rv0), 0);
      check("one_hold", 64'(res), 8);
      check("one_idle", 64'(alu_ctrl), 0);
      check("one_cnt0", 64'(cnt0), 3);

      // zero flag via port 1 SUB
      v1 = 1; a1 = 32'h1234; b1 = 32'h1234; op1 = 4'b0110;
      #1;
      check("z_rdy1", 64'(rdy1), 1);
      tick();
      v1 = 0;
      tick();
      check("z_rv1", 64'(rv1), 1);
      check("z_rv0", 64'(rv0), 0);
      check("z_res", 64'(res), 0);
      check("z_zero", 64'(zero), 1);
      tick();

      // stall with both valid
      stall = 1; v0 = 1; v1 = 1;
      a0 = 32'd7; b0 = 32'd9; op0 = 4'b0001;
      a1 = 32'd1; b1 = 32'd1; op1 = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_rdy0", 64'(rdy0), 0);
         check("st_rdy1", 64'(rdy1), 0);
         check("st_ctrl", 64'(alu_ctrl), 0);
         tick();
      end
      check("st_cnt1", 64'(cnt1), 3);
      stall = 0;
      #1;
      check("st_drop0", 64'(rdy0), 1);
      check("st_drop1", 64'(rdy1), 0);
      tick();
      stall = 1;
      #1;
      check("dr_rdy1", 64'(rdy1), 0);
      check("dr_ctrl", 64'(alu_ctrl), 1);
      tick();
      check("dr_rv0", 64'(rv0), 1);
      check("dr_res", 64'(res), 15);
      tick();
      check("dr_idle", 64'(alu_ctrl), 0);
      check("dr_pulse", 64'(rv0), 0);
      stall = 0; v0 = 0;
      #1;
      check("only1_rdy", 64'(rdy1), 1);
      v1 = 0;
      tick();

      // reset one cycle after an accept
      v0 = 1; a0 = 32'd1; b0 = 32'd1; op0 = 4'b0010;
      tick();
      v0 = 0;
      #1;
      rst_n = 0;
      #1;
      check("mr_rv0", 64'(rv0), 0);
      check("mr_alu_a", 64'(alu_a), 0);
      check("mr_ctrl", 64'(alu_ctrl), 0);
      check("mr_res", 64'(res), 0);
      check("mr_cnt0", 64'(cnt0), 0);
      check("mr_cnt1", 64'(cnt1), 0);
      tick();
      rst_n = 1;
      tick();
      check("mr_post0", 64'(rv0), 0);
      check("mr_post1", 64'(rv1), 0);
      v0 = 1; v1 = 1;
      #1;
      check("mr_lgp0", 64'(rdy0), 1);
      check("mr_lgp1", 64'(rdy1), 0);
      v0 = 0; v1 = 0;
      tick();

      // saturation
      v0 = 1;
      repeat (65534) @(posedge clk);
      #1;
      check("sat_fffe", 64'(cnt0), 64'hFFFE);
      @(posedge clk);
      #1;
      check("sat_ffff", 64'(cnt0), 64'hFFFF);
      repeat (2) @(posedge clk);
      #1;
      v0 = 0;
      check("sat_hold", 64'(cnt0), 64'hFFFF);
      check("sat_cnt1", 64'(cnt1), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
